// File: rtl/fpu_mux_pkg.sv
// rtl/fpu_mux_pkg.sv - shared state encoding and parameter helpers for the registered N:1 mux
package fpu_mux_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    function automatic int fpu_mux_clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_n_1_comb.sv
// rtl/mux_n_1_comb.sv - combinational N:1 channel selector; indices past the last channel fall back to channel 0
module mux_n_1_comb #(
    parameter int DataSize  = 8,
    parameter int NumInputs = 4,
    parameter int SelWidth  = 2
) (
    input  logic [NumInputs*DataSize-1:0] choices_i,
    input  logic [SelWidth-1:0]           sel_i,
    output logic [DataSize-1:0]           data_o
);

    always_comb begin
        data_o = choices_i[DataSize-1:0];
        for (int k = 1; k < NumInputs; k++) begin
            if (sel_i == SelWidth'(k)) begin
                data_o = choices_i[k*DataSize +: DataSize];
            end
        end
    end

endmodule

// File: rtl/mux_n_1_pipe.sv
// rtl/mux_n_1_pipe.sv - registered N:1 mux with two-entry skid buffer and registered InReady
// Optional MUX_SEL_CHECK_EN: out-of-range Sel beats are dropped and raise sticky SelError.
module mux_n_1_pipe
    import fpu_mux_pkg::*;
#(
    parameter int DataSize  = 8,
    parameter int NumInputs = 4,
    parameter int SelWidth  = 2
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic [NumInputs*DataSize-1:0] Choices,
    input  logic [SelWidth-1:0]           Sel,
    input  logic                          InValid,
    output logic                          InReady,
    output logic [DataSize-1:0]           Output,
    output logic [SelWidth-1:0]           OutSel,
    output logic                          OutValid,
    input  logic                          OutReady
`ifdef MUX_SEL_CHECK_EN
    ,
    output logic                          SelError
`endif
);

    if (NumInputs < 2 || NumInputs > 16 || SelWidth < fpu_mux_clog2(NumInputs)) begin : g_param_err
        $error("mux_n_1_pipe: illegal NumInputs/SelWidth combination");
    end

    state_t                state_q, state_d;
    logic [DataSize-1:0]   main_data_q, main_data_d;
    logic [SelWidth-1:0]   main_sel_q, main_sel_d;
    logic [DataSize-1:0]   skid_data_q, skid_data_d;
    logic [SelWidth-1:0]   skid_sel_q, skid_sel_d;
    logic                  in_ready_q, in_ready_d;
    logic [DataSize-1:0]   sel_data;
    logic                  accept;
    logic                  drain;
    logic                  load;

    mux_n_1_comb #(
        .DataSize  (DataSize),
        .NumInputs (NumInputs),
        .SelWidth  (SelWidth)
    ) u_sel (
        .choices_i (Choices),
        .sel_i     (Sel),
        .data_o    (sel_data)
    );

    assign accept = InValid & in_ready_q;
    assign drain  = (state_q != ST_EMPTY) & OutReady;

`ifdef MUX_SEL_CHECK_EN
    logic sel_in_range;
    logic sel_err_q, sel_err_d;

    // A rejected beat still completes the handshake; it just never enters storage.
    assign sel_in_range = (Sel <= SelWidth'(NumInputs - 1));
    assign load         = accept & sel_in_range;
    assign sel_err_d    = sel_err_q | (accept & ~sel_in_range);
    assign SelError     = sel_err_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end
`else
    assign load = accept;
`endif

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        case (state_q)
            ST_EMPTY: begin
                if (load) begin
                    state_d     = ST_ONE;
                    main_data_d = sel_data;
                    main_sel_d  = Sel;
                end
            end
            ST_ONE: begin
                if (load && !drain) begin
                    state_d     = ST_TWO;
                    skid_data_d = sel_data;
                    skid_sel_d  = Sel;
                end else if (load && drain) begin
                    main_data_d = sel_data;
                    main_sel_d  = Sel;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (drain) begin
                    state_d     = ST_ONE;
                    main_data_d = skid_data_q;
                    main_sel_d  = skid_sel_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign InReady  = in_ready_q;
    assign Output   = main_data_q;
    assign OutSel   = main_sel_q;
    assign OutValid = (state_q != ST_EMPTY);

endmodule
